// File: rtl/alu_pkg.sv
// Opcode encoding, flag layout and legality check shared by the ALU and its command sequencer.
package alu_pkg;

  localparam int OPCODE_W = 4;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_ADD = 4'd0;
  localparam opcode_t OP_SUB = 4'd1;
  localparam opcode_t OP_AND = 4'd2;
  localparam opcode_t OP_OR  = 4'd3;
  localparam opcode_t OP_XOR = 4'd4;
  localparam opcode_t OP_NOT = 4'd5;
  localparam opcode_t OP_SHL = 4'd6;
  localparam opcode_t OP_SHR = 4'd7;
  localparam opcode_t OP_MUL = 4'd8;
  localparam opcode_t OP_SAR = 4'd9;
  localparam opcode_t OP_INC = 4'd10;
  localparam opcode_t OP_DEC = 4'd11;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic zero;
  } flags_t;

  // Encodings above OP_DEC are reserved and reported as errors.
  function automatic logic is_legal_op(input opcode_t op);
    return op <= OP_DEC;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Latency: count visible one cycle after inc; no backpressure.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Registers ALU operands from a command stream, captures result/flags, keeps a chaining accumulator.
// Latency: 2 cycles accept-to-response (1 for illegal opcodes); new commands wait while a response is unconsumed.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  input  logic                    cmd_use_acc,
  input  logic                    cmd_wr_acc,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_carry,
  input  logic                    alu_overflow,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_result,
  output logic [2:0]              rsp_flags,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   acc_q,
  output logic [CNT_WIDTH-1:0]    ops_done,
  output logic [CNT_WIDTH-1:0]    err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0] state;
  logic       wr_acc_q;
  flags_t     flags_q;
  logic       accept;
  logic       legal;
  logic       exec_done;
  logic       illegal_accept;

  // A pending response may be retired and replaced in the same cycle.
  assign cmd_ready      = (state == ST_IDLE) | ((state == ST_RESP) & rsp_ready);
  assign rsp_valid      = (state == ST_RESP);
  assign accept         = cmd_valid & cmd_ready;
  assign legal          = is_legal_op(opcode_t'(cmd_opcode));
  assign exec_done      = (state == ST_EXEC);
  assign illegal_accept = accept & ~legal;
  assign rsp_flags      = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_acc_q   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_result <= '0;
      flags_q    <= '0;
      rsp_err    <= 1'b0;
      acc_q      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            if (legal) begin
              alu_a      <= cmd_use_acc ? acc_q : cmd_a;
              alu_b      <= cmd_b;
              alu_opcode <= cmd_opcode;
              wr_acc_q   <= cmd_wr_acc;
              state      <= ST_EXEC;
            end else begin
              // Illegal ops skip the ALU entirely and leave its operands untouched.
              rsp_result <= '0;
              flags_q    <= '0;
              rsp_err    <= 1'b1;
              state      <= ST_RESP;
            end
          end else if ((state == ST_RESP) && rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rsp_result       <= alu_result;
          flags_q.overflow <= alu_overflow;
          flags_q.carry    <= alu_carry;
          flags_q.zero     <= alu_zero;
          rsp_err          <= 1'b0;
          if (wr_acc_q) begin
            acc_q <= alu_result;
          end
          state <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_ops_done (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (exec_done),
    .count (ops_done)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (illegal_accept),
    .count (err_count)
  );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and random bench for alu_cmd_sequencer with a behavioural ALU and command-level model.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic        cmd_use_acc = 1'b0;
  logic        cmd_wr_acc = 1'b0;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_result;
  logic        alu_zero, alu_carry, alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_result;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic [7:0]  acc_q;
  logic [15:0] ops_done, err_count;

  int errors = 0;
  int checks = 0;

  // Command-level model state
  logic [7:0]  m_acc = '0;
  logic [15:0] m_ops = '0;
  logic [15:0] m_err = '0;
  logic [7:0]  m_alu_a = '0, m_alu_b = '0;
  logic [3:0]  m_alu_op = '0;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .acc_q(acc_q),
    .ops_done(ops_done), .err_count(err_count)
  );

  // Returns {overflow, carry, zero, result[7:0]}.
  function automatic logic [10:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  w;
    logic [15:0] p;
    logic [7:0]  r;
    logic        c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0:  begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1:  begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a;
      4'd6:  begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'd7:  begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'd8:  begin p = a * b; r = p[7:0]; c = |p[15:8]; end
      4'd9:  begin r = {a[7], a[7:1]}; c = a[0]; end
      4'd10: begin w = {1'b0, a} + 9'd1; r = w[7:0]; c = w[8]; v = (a == 8'h7F); end
      4'd11: begin w = {1'b0, a} - 9'd1; r = w[7:0]; c = w[8]; v = (a == 8'h80); end
      default: r = '0;
    endcase
    return {v, c, (r == 8'h00), r};
  endfunction

  always_comb begin
    {alu_overflow, alu_carry, alu_zero, alu_result} = alu_ref(alu_opcode, alu_a, alu_b);
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Issues one command from IDLE, checks latency and response, holds rsp_ready low for hold cycles.
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ua, input logic wa, input int hold);
    logic        legal;
    logic [7:0]  opa;
    logic [10:0] r;
    logic [7:0]  exp_res;
    logic [2:0]  exp_flg;
    int          w, lat;
    legal = (op < 4'd12);
    opa   = ua ? m_acc : a;
    r     = alu_ref(op, opa, b);
    exp_res = legal ? r[7:0] : 8'h00;
    exp_flg = legal ? r[10:8] : 3'b000;
    if (legal) begin
      if (wa) m_acc = r[7:0];
      if (m_ops != 16'hFFFF) m_ops++;
      m_alu_a = opa; m_alu_b = b; m_alu_op = op;
    end else if (m_err != 16'hFFFF) begin
      m_err++;
    end

    @(negedge clk);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_wr_acc = wa; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 10) begin @(negedge clk); w++; end
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin @(negedge clk); lat++; end
    check({tag, "_latency"}, lat, legal ? 2 : 1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_result"}, rsp_result, exp_res);
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
      @(negedge clk);
    end
    check({tag, "_result"}, rsp_result, exp_res);
    check({tag, "_flags"}, rsp_flags, exp_flg);
    check({tag, "_err"}, rsp_err, !legal);
    check({tag, "_acc"}, acc_q, m_acc);
    check({tag, "_ops_done"}, ops_done, m_ops);
    check({tag, "_err_count"}, err_count, m_err);
    check({tag, "_alu_a"}, alu_a, m_alu_a);
    check({tag, "_alu_b"}, alu_b, m_alu_b);
    check({tag, "_alu_op"}, alu_opcode, m_alu_op);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_idle_after"}, rsp_valid, 0);
  endtask

  initial begin
    int n_acc, n_rsp, cyc, last_acc;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_acc", acc_q, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_err_count", err_count, 0);
    check("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    check("rst_rsp", {rsp_result, rsp_flags, rsp_err}, 0);
    rst_n = 1'b1;

    // Back-to-back accumulator chain with rsp_ready held high
    @(negedge clk);
    rsp_ready = 1'b1;
    cmd_opcode = OP_INC; cmd_a = 8'hA5; cmd_b = 8'h3C; cmd_use_acc = 1'b1; cmd_wr_acc = 1'b1;
    cmd_valid = 1'b1;
    n_acc = 0; n_rsp = 0; cyc = 0; last_acc = 0;
    while (n_rsp < 3 && cyc < 40) begin
      if (rsp_valid) begin
        m_acc = m_acc + 8'd1;
        m_ops++;
        check("chain_result", rsp_result, m_acc);
        n_rsp++;
      end
      if (cmd_valid && cmd_ready) begin
        if (n_acc > 0) check("chain_gap", cyc - last_acc, 2);
        last_acc = cyc;
        n_acc++;
      end
      @(negedge clk);
      cyc++;
      if (n_acc == 3) cmd_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    m_alu_a = 8'h02; m_alu_b = 8'h3C; m_alu_op = OP_INC;
    check("chain_responses", n_rsp, 3);
    check("chain_acc", acc_q, 8'h03);
    check("chain_ops_done", ops_done, 3);

    // Directed cases
    run_cmd("add", OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b1, 0);
    run_cmd("sub", OP_SUB, 8'h00, 8'h01, 1'b0, 1'b0, 0);
    run_cmd("mul", OP_MUL, 8'h10, 8'h10, 1'b0, 1'b0, 0);
    run_cmd("illegal", 4'hC, 8'h55, 8'hAA, 1'b0, 1'b1, 0);
    run_cmd("bp", OP_XOR, 8'h3C, 8'hF0, 1'b0, 1'b1, 5);
    run_cmd("bp_illegal", 4'hF, 8'h01, 8'h02, 1'b1, 1'b0, 3);

    // Random commands against the model
    for (int k = 0; k < 40; k++) begin
      run_cmd("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset while in EXEC drops the command
    run_cmd("preload", OP_ADD, 8'h11, 8'h22, 1'b0, 1'b1, 0);
    @(negedge clk);
    cmd_opcode = OP_ADD; cmd_a = 8'h05; cmd_b = 8'h06; cmd_use_acc = 1'b0; cmd_wr_acc = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("exec_cmd_ready", cmd_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_acc", acc_q, 0);
    check("mid_rst_counters", {ops_done, err_count}, 0);
    check("mid_rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    check("post_rst_cmd_ready", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator side of the ALU interface. Accepts operation commands on a valid/ready stream and drives registered operands and opcode into the combinational ALU. It captures the ALU result and flags, keeps an 8-bit accumulator for chained operations, and returns one response per command on a valid/ready stream. Sits between the command source (test controller or host FSM) and the ALU instance.

Parameters:
DATA_WIDTH, 8, operand/result/accumulator width
OPCODE_WIDTH, 4, opcode width; encoding shared with ALU via package
CNT_WIDTH, 16, width of saturating status counters

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command this cycle
cmd_opcode  in  OPCODE_WIDTH  ALU operation
cmd_a  in  DATA_WIDTH  operand A (ignored when cmd_use_acc=1)
cmd_b  in  DATA_WIDTH  operand B
cmd_use_acc  in  1  take operand A from accumulator
cmd_wr_acc  in  1  write result into accumulator
alu_a  out  DATA_WIDTH  registered operand A to ALU
alu_b  out  DATA_WIDTH  registered operand B to ALU
alu_opcode  out  OPCODE_WIDTH  registered opcode to ALU
alu_result  in  DATA_WIDTH  ALU result
alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_result  out  DATA_WIDTH  captured result
rsp_flags  out  3  {overflow, carry, zero}
rsp_err  out  1  illegal opcode (12..15)
acc_q  out  DATA_WIDTH  accumulator value
ops_done  out  CNT_WIDTH  count of legal ops completed, saturating
err_count  out  CNT_WIDTH  count of illegal-opcode commands, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc_q, alu_a, alu_b, alu_opcode, rsp_result, rsp_flags, rsp_err, ops_done, err_count = 0; rsp_valid=0. cmd_ready is combinational and equals 1 in IDLE.
- States: IDLE, EXEC, RESP.
- cmd_ready = (state==IDLE) | (state==RESP & rsp_ready). A command is accepted on cmd_valid & cmd_ready.
- On accept with a legal opcode (0..11), in the same edge: alu_a <= cmd_use_acc ? acc_q : cmd_a; alu_b <= cmd_b; alu_opcode <= cmd_opcode; latch wr_acc; go to EXEC.
- EXEC (exactly 1 cycle): the ALU evaluates the registered operands combinationally. At the end of the cycle: rsp_result <= alu_result; rsp_flags <= {alu_overflow, alu_carry, alu_zero}; rsp_err <= 0; if wr_acc then acc_q <= alu_result; ops_done++ (saturating). Go to RESP.
- On accept with an illegal opcode (12..15): no EXEC and no change to the alu_* registers. rsp_result <= 0, rsp_flags <= 0, rsp_err <= 1, err_count++ (saturating). Go directly to RESP.
- RESP: rsp_valid=1. rsp_result, rsp_flags and rsp_err are held stable until rsp_ready=1.
  - rsp_ready & !cmd_valid -> IDLE.
  - rsp_ready & cmd_valid -> accept the new command in the same cycle (EXEC or RESP per opcode).
- Latency: accept at edge N; rsp_valid visible after edge N+2 for legal ops, after edge N+1 for illegal ops. Peak throughput is 1 legal op per 2 cycles.
- Accumulator hazard: the accumulator is written at the EXEC->RESP edge. A use_acc command can be accepted no earlier than RESP, so it always sees the updated acc_q.
- Counters saturate at all-ones and never wrap.
- Reset mid-operation: any in-flight command is dropped, no response is produced, and all state returns to its reset values.
- Undefined state encodings recover to IDLE.

Decomposition:
- Shared package alu_pkg: opcode localparams (ADD=0 … DEC=11), an opcode_t typedef, an is_legal_op() function, and a flags_t struct {overflow, carry, zero}. The ALU and this block both import it.
- One natural sub-module: sat_counter (parameterised width, inc input, saturating), instantiated for ops_done and err_count.

Test Plan:
- ADD a=0x7F b=0x01, wr_acc=1 -> rsp_result=0x80, flags={1,0,0}, acc_q=0x80, rsp_valid 2 cycles after accept.
- SUB a=0x00 b=0x01 -> rsp_result=0xFF, flags={0,1,0}; acc_q unchanged when wr_acc=0.
- Accumulator chain after reset: INC with use_acc=1 and wr_acc=1, issued back-to-back 3 times with rsp_ready=1 -> results 0x01, 0x02, 0x03, acc_q=0x03, ops_done=3, one accept every 2 cycles.
- MUL a=0x10 b=0x10 -> rsp_result=0x00, flags={0,1,1}.
- Illegal opcode 0xC -> rsp_err=1, result=0, flags=0, rsp_valid 1 cycle after accept, err_count=1, alu_* outputs unchanged.
- Backpressure and reset: hold rsp_ready=0 for 5 cycles -> response stable and cmd_ready=0 throughout. Then assert rst_n=0 during EXEC -> rsp_valid=0 and acc_q=0 immediately, and no response after reset release.
